// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed byte stream, assembles 16-bit words high byte first,
// writes them to instruction memory from address 0 and holds the CPU in reset until done.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_LEN,
    S_HI,
    S_LO,
    S_WRITE,
    S_DONE
`ifdef LOADER_CHECKSUM_EN
    ,
    S_CSUM,
    S_ERROR
`endif
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [CW-1:0] len_clamped;
  logic          accept;
  logic          last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    sum;
  logic          err_q;
`endif

  assign rx_ready  = (state == S_LEN) || (state == S_HI) || (state == S_LO)
`ifdef LOADER_CHECKSUM_EN
                     || (state == S_CSUM)
`endif
                     ;
  assign accept    = rx_valid && rx_ready;
  assign last_word = (count == CW'(1));

  always_comb begin
    len_clamped = CW'(rx_data);
    if (32'(rx_data) > DEPTH) len_clamped = CW'(DEPTH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LEN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LEN: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = (rx_data == 8'd0) ? S_CSUM : S_HI;
`else
          state_next = (rx_data == 8'd0) ? S_DONE : S_HI;
`endif
        end
      end
      S_HI:    if (accept) state_next = S_LO;
      S_LO:    if (accept) state_next = S_WRITE;
      S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
        state_next = last_word ? S_CSUM : S_HI;
`else
        state_next = last_word ? S_DONE : S_HI;
`endif
      end
      S_DONE:  if (reload) state_next = S_LEN;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:  if (accept) state_next = (rx_data == sum) ? S_DONE : S_ERROR;
      S_ERROR: if (reload) state_next = S_LEN;
`endif
      default: state_next = S_LEN;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      count      <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      imem_we   <= (state_next == S_WRITE);
      cpu_hold  <= (state_next != S_DONE);
      load_done <= (state_next == S_DONE);
`ifdef LOADER_CHECKSUM_EN
      err_q     <= (state_next == S_ERROR);
`endif
      case (state)
        S_LEN: if (accept) begin
          count     <= len_clamped;
          imem_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
          sum       <= rx_data;
`endif
        end
        S_HI: if (accept) begin
          imem_wdata[15:8] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
          sum              <= sum + rx_data;
`endif
        end
        S_LO: if (accept) begin
          imem_wdata[7:0] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
          sum             <= sum + rx_data;
`endif
        end
        S_WRITE: begin
          count <= count - CW'(1);
          // Address holds on the final word so it never points past DEPTH-1.
          if (!last_word) imem_addr <= imem_addr + 8'd1;
        end
        S_DONE: if (reload) begin
          imem_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
          sum       <= '0;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        S_ERROR: if (reload) begin
          imem_addr <= '0;
          sum       <= '0;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected (addr,data) writes,
// a monitor pops and compares on every imem_we pulse.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        err;

  int compared   = 0;
  int mismatched = 0;

  logic [23:0] exp_q[$];
  logic [15:0] img[$];

  program_loader #(.DEPTH(256)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each write strobe must match the oldest expected write, with rx_ready low.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {8'h0, imem_addr, imem_wdata}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(imem_addr), 32'(e[23:16]));
          check("write_data", 32'(imem_wdata), 32'(e[15:0]));
        end
        check("rx_ready_in_write", 32'(rx_ready), 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'hFF;
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) check("byte_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gap, input logic [7:0] csum_xor);
    logic [7:0] s;
    s = 8'(img.size());
    foreach (img[i]) exp_q.push_back({i[7:0], img[i]});
    send_byte(s, gap);
    foreach (img[i]) begin
      send_byte(img[i][15:8], gap);
      send_byte(img[i][7:0], gap);
      s = s + img[i][15:8] + img[i][7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(s ^ csum_xor, gap);
`else
    if (csum_xor != 8'h00) $display("note: checksum feature absent, checksum byte not sent");
`endif
  endtask

  task automatic wait_end();
    int n = 0;
    while (load_done !== 1'b1 && err !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (load_done !== 1'b1 && err !== 1'b1) check("end_of_frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check("reload_load_done", 32'(load_done), 32'd0);
    check("reload_cpu_hold", 32'(cpu_hold), 32'd1);
    check("reload_err", 32'(err), 32'd0);
    check("reload_rx_ready", 32'(rx_ready), 32'd1);
    check("reload_addr", 32'(imem_addr), 32'd0);
  endtask

  task automatic check_done(input string tag);
    check({tag, "_load_done"}, 32'(load_done), 32'd1);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reload   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");

    // Basic two-word frame with exact completion latency.
    img = '{16'hC105, 16'h0A12};
    send_frame(1'b0, 8'h00);
`ifndef LOADER_CHECKSUM_EN
    check("last_write_we", 32'(imem_we), 32'd1);
    check("done_not_early", 32'(load_done), 32'd0);
    @(posedge clk);
    #1;
`endif
    check_done("frame1");

    // Same frame with rx_valid gaps between bytes.
    pulse_reload();
    send_frame(1'b1, 8'h00);
    wait_end();
    check_done("frame_gaps");

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum (00 instead of 34) must fault and keep the CPU held.
    pulse_reload();
    img = '{16'h1122};
    send_frame(1'b0, 8'h34);
    wait_end();
    check("bad_csum_err", 32'(err), 32'd1);
    check("bad_csum_cpu_hold", 32'(cpu_hold), 32'd1);
    check("bad_csum_load_done", 32'(load_done), 32'd0);
    check("bad_csum_pending", 32'(exp_q.size()), 32'd0);
    pulse_reload();
    send_frame(1'b0, 8'h00);
    wait_end();
    check_done("good_csum");
`endif

    // Zero-length frame: no writes, straight to done.
    pulse_reload();
    img.delete();
    send_frame(1'b0, 8'h00);
    wait_end();
    check_done("len0");

    // Reset after the first HI byte of a three-word frame.
    pulse_reload();
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    img = '{16'hBEEF, 16'h1234, 16'h00FF};
    send_frame(1'b1, 8'h00);
    wait_end();
    check_done("after_reset");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
